// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor: the operands are cut into STAGES slices that are
// added LSB-first, one slice per stage, with the carry registered between stages.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int W = WIDTH / STAGES;

  // Per-stage state: operands travel unchanged; the sum fills in one slice per stage.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic [W:0]        tot;

  assign in_ready  = !(out_valid && !out_ready);
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

  always_comb begin
    // Subtract is folded into stage 0 as a + ~b + 1 so later stages only ever add.
    src_a[0] = in_a;
    src_b[0] = in_sub ? ~in_b : in_b;
    src_s[0] = '0;
    src_c[0] = in_sub | in_cin;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end
    tot = '0;
    c_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      tot = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]} + {{W{1'b0}}, src_c[k]};
      s_d[k] = src_s[k];
      s_d[k][k*W +: W] = tot[W-1:0];
      c_d[k] = tot[W];
    end
    // Carry into the MSB recovered from sum ^ a ^ b at that bit.
    ovf_d = c_d[STAGES-1] ^ (s_d[STAGES-1][WIDTH-1] ^ src_a[STAGES-1][WIDTH-1]
                             ^ src_b[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (in_ready) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (src_v[STAGES-1]) ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: 8-bit/2-stage and 16-bit/4-stage instances checked against an
// arithmetic reference model through per-instance scoreboards plus directed cases.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v8, r8, cin8, sub8, ov8, ordy8, co8, of8;
  logic [7:0]  a8, b8, sum8;
  logic        v16, r16, cin16, sub16, ov16, ordy16, co16, of16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int errors = 0;
  logic [17:0] q8[$];
  logic [17:0] q16[$];

  pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_cin(cin8), .in_sub(sub8), .out_valid(ov8), .out_ready(ordy8), .out_sum(sum8),
    .out_cout(co8), .out_ovf(of8)
  );

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
    .in_cin(cin16), .in_sub(sub16), .out_valid(ov16), .out_ready(ordy16), .out_sum(sum16),
    .out_cout(co16), .out_ovf(of16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic, signed overflow from operand/result signs.
  function automatic logic [17:0] model(input int unsigned w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin, input logic sub);
    longint unsigned mask, la, lb, full, s;
    logic co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    la   = a;
    lb   = b;
    if (sub) lb = mask ^ lb;
    full = la + lb + (sub ? 64'd1 : {63'd0, cin});
    s    = full & mask;
    co   = full[w];
    sa   = la[w-1];
    sb   = lb[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, s[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      q16.delete();
    end else begin
      if (ov8 && ordy8) begin
        if (q8.size() == 0) check("sb8_spurious", {31'd0, ov8}, 32'd0);
        else check("sb8", {14'd0, of8, co8, 8'h00, sum8}, {14'd0, q8.pop_front()});
      end
      if (v8 && r8) q8.push_back(model(8, {8'h00, a8}, {8'h00, b8}, cin8, sub8));
      if (ov16 && ordy16) begin
        if (q16.size() == 0) check("sb16_spurious", {31'd0, ov16}, 32'd0);
        else check("sb16", {14'd0, of16, co16, sum16}, {14'd0, q16.pop_front()});
      end
      if (v16 && r16) q16.push_back(model(16, a16, b16, cin16, sub16));
    end
  end

  task automatic directed8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input logic [7:0] es,
                           input logic ec, input logic eo);
    int n;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) v8 = 1'b0;
    end while (!ov8 && n < 20);
    check({tag, "_lat"}, n, 2);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, co8}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, of8}, {31'd0, eo});
  endtask

  task automatic directed16(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input logic [15:0] es,
                            input logic ec, input logic eo);
    int n;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) v16 = 1'b0;
    end while (!ov16 && n < 20);
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, {16'd0, sum16}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, co16}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, of16}, {31'd0, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_a;
    rst_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
    #1;
    check("rst_ov8", {31'd0, ov8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_flags8", {30'd0, co8, of8}, 32'd0);
    check("rst_ready8", {31'd0, r8}, 32'd1);
    check("rst_ov16", {31'd0, ov16}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ov8", {31'd0, ov8}, 32'd0);
    rst_n = 1'b1;

    // First accept on the first edge after release.
    directed8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directed8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    directed8("add_0f_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    directed8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    directed16("w16_add", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Ten back-to-back beats: valid results expected on edges 1..10 after the first accept.
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
      end else v8 = 1'b0;
      @(posedge clk); #1;
      check("b2b_valid", {31'd0, ov8}, (k >= 1 && k <= 10) ? 32'd1 : 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Stall with a result held at the output.
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; v8 = 1'b1;
    exp_a = model(8, 16'h003C, 16'h005A, 1'b1, 1'b0);
    @(posedge clk); #1;
    a8 = 8'hC3; b8 = 8'h11; sub8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0; a8 = 8'h42; b8 = 8'h24; sub8 = 1'b0;
    #1;
    check("stall_ready", {31'd0, r8}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_ready_hold", {31'd0, r8}, 32'd0);
      check("stall_valid", {31'd0, ov8}, 32'd1);
      check("stall_data", {14'd0, of8, co8, 8'h00, sum8}, {14'd0, exp_a});
    end
    ordy8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_drained", q8.size(), 0);

    // Reset with two beats in flight.
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    a8 = 8'h56; b8 = 8'h78;
    @(posedge clk); #1;
    v8 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_ov", {31'd0, ov8}, 32'd0);
    check("mrst_sum", {24'd0, sum8}, 32'd0);
    check("mrst_flags", {30'd0, co8, of8}, 32'd0);
    check("mrst_ready", {31'd0, r8}, 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("mrst_quiet", {31'd0, ov8}, 32'd0);
    end
    directed8("post_rst_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with random backpressure on both instances.
    for (int k = 0; k < 400; k++) begin
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom); ordy8 = ($urandom_range(0, 3) != 0);
      v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom); ordy16 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    v8 = 1'b0; ordy8 = 1'b1;
    v16 = 1'b0; ordy16 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("final_q8_empty", q8.size(), 0);
    check("final_q16_empty", q16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 2: number of pipeline stages; SHALL be at least 1 and SHALL divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in, used only for add.
REQ-010 in_sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 out_cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
REQ-015 out_ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add (in_sub=0) SHALL compute in_a + in_b + in_cin.
REQ-017 Subtract (in_sub=1) SHALL compute in_a + ~in_b + 1, and SHALL ignore in_cin.
REQ-018 Segmentation: the operands SHALL be split into STAGES slices of W=WIDTH/STAGES bits, LSB slice first.
REQ-019 Stage k SHALL add slice k plus the registered carry from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-020 Operand slices not yet consumed, and result slices already produced, SHALL travel with the beat in skew registers.
REQ-021 Latency SHALL be exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid=1 for that beat, with no stall.
REQ-022 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-023 Each stage SHALL hold a valid bit; beats SHALL leave in the order they were accepted.
REQ-024 in_ready SHALL equal !(out_valid & !out_ready); the whole pipeline SHALL advance only when in_ready=1.
REQ-025 While stalled (in_ready=0), every stage register and out_* output SHALL hold its value.
REQ-026 Bubbles: an invalid input cycle SHALL propagate as valid=0; bubbles SHALL NOT be collapsed.
REQ-027 out_ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, taken from the final stage.
REQ-028 out_cout SHALL be the carry out of the final stage.
REQ-029 out_sum, out_cout and out_ovf SHALL be registered outputs, with no combinational path from in_*.
REQ-030 in_ready SHALL depend combinationally only on out_valid and out_ready.
REQ-031 Data-path registers SHALL update only when the valid bit of that stage's source is 1; data held under valid=0 is don't-care.
REQ-032 STAGES=1 SHALL degenerate to a registered WIDTH-bit adder with latency 1.

Reset
REQ-033 While rst_n=0, all stage valid bits and out_valid SHALL be 0, and out_sum, out_cout and out_ovf SHALL be 0, regardless of clk.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats; none SHALL appear after release.
REQ-035 in_ready SHALL be 1 during and immediately after reset.
REQ-036 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-037 Add 0xFF + 0x01, cin=0, accepted at cycle 0 -> out_valid=1 at cycle 2 with out_sum=0x00, cout=1, ovf=0.
REQ-038 Add 0x7F + 0x01, cin=0 -> out_sum=0x80, cout=0, ovf=1; add 0x0F + 0x00, cin=1 -> out_sum=0x10, checking that the carry crosses the slice boundary.
REQ-039 Sub 0x05 - 0x07, with cin=1 (ignored) -> out_sum=0xFE, cout=0, ovf=0; sub 0x80 - 0x01 -> out_sum=0x7F, cout=1, ovf=1.
REQ-040 Ten back-to-back beats with random operands and out_ready=1 -> ten results on ten consecutive cycles, in order, matching a reference model.
REQ-041 Hold out_ready=0 for 3 cycles while a result is at the output -> in_ready=0, outputs stable; after release, no beat is lost or duplicated.
REQ-042 Assert rst_n=0 with 2 beats in flight -> outputs go to 0 immediately; after release, out_valid stays 0 until a new beat completes. Repeat REQ-037 with WIDTH=16, STAGES=4 -> latency 4.
